cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter and broadcast register for the single common data bus (CDB). Each functional unit (FU) raises a request with its result, valid bit, reorder-buffer (RB) index and, for storers, an effective address. The arbiter grants one FU per cycle and drives the registered broadcast that the CDB data controller and reservation stations consume. Grant order is fair, so no FU waits more than FU_NUM-1 grants.

## Interface
- WORD_SIZE, 32, data/address width
- FU_NUM, 4, number of requesting FUs
- STORER_NUM, 1, number of store units; these are FUs FU_NUM-STORER_NUM .. FU_NUM-1
- RB_INDEX, 4, RB index width; all-ones value is NULL
- FU_ID_W, 2, width of winner id; at least clog2(FU_NUM)
- clk  in  1  clock, posedge
- reset  in  1  one clock; reset is asynchronous and active-low
- flush  in  1  synchronous pipeline flush (mispredict)
- req  in  FU_NUM  per-FU broadcast request; level, held until granted
- data_bus  in  WORD_SIZE*FU_NUM  FU i result at [i*WORD_SIZE +: WORD_SIZE]
- valid_bus  in  FU_NUM  FU i result-valid bit
- addr_bus  in  STORER_NUM*WORD_SIZE  storer j address at [j*WORD_SIZE +: WORD_SIZE]
- RB_index_bus  in  FU_NUM*RB_INDEX  FU i target RB entry at [i*RB_INDEX +: RB_INDEX]
- grant  out  FU_NUM  one-hot, one-cycle grant
- cdb_valid  out  1  broadcast present this cycle
- cdb_data  out  WORD_SIZE  broadcast result
- cdb_ok  out  1  copy of winner's valid_bus bit
- cdb_addr  out  WORD_SIZE  winner's address if storer, else 0
- cdb_rb_index  out  RB_INDEX  winner's RB entry
- cdb_fu  out  FU_ID_W  winner's FU number

## Operation
- State: rotating pointer ptr (0..FU_NUM-1), registered outputs.
- Eligible FU i: req[i]=1, RB index != NULL, and grant[i]=0 in the current cycle. The last condition masks the FU still seeing its grant, so there is no double grant.
- Request with NULL RB index is never granted and never blocks others.
- Winner: first eligible FU searching ptr, ptr+1, ... wrapping modulo FU_NUM.
- On a winner w at a clock edge (flush=0):
  - grant becomes one-hot bit w.
  - cdb_valid=1.
  - cdb_data, cdb_ok, cdb_rb_index are captured from FU w's lanes; cdb_fu=w.
  - cdb_addr = addr_bus lane w-(FU_NUM-STORER_NUM) if w is a storer, else 0.
  - ptr becomes (w+1) mod FU_NUM.
- No eligible FU: grant=0, cdb_valid=0. The data outputs hold their previous values and ptr is unchanged.
- flush=1 at an edge: grant=0 and cdb_valid=0. Requests sampled that edge are discarded and ptr is unchanged. Flush overrides any winner.
- FU protocol: hold req and lanes stable until grant seen high. Deassert or present the next result at the following edge. Back-to-back grants to the same FU are impossible, so a single FU gets at most one grant every 2 cycles.

## Timing
- Reset (reset=0, asynchronous): grant=0, cdb_valid=0, cdb_data=0, cdb_ok=0, cdb_addr=0, cdb_rb_index=NULL (all ones), cdb_fu=0, ptr=0. These values hold while reset is low.
- Release: the first edge with reset=1 arbitrates normally.
- Latency: a request sampled at edge N gives grant and broadcast valid during cycle N..N+1 (one register stage).
- Throughput: one broadcast per cycle whenever 2 or more FUs alternate requests.
- Fairness: a continuously held eligible request is granted within FU_NUM cycles.
- Reset asserted mid-broadcast clears outputs immediately, without waiting for a clock. Requests pending at reset get no grant.
- Requests arriving in the same cycle as a flush must be re-presented by the FU afterwards.

## Test plan
- Reset then idle: reset=0 for 3 cycles, then release with req=0 -> all outputs at reset values, cdb_rb_index=4'hF, no grant for 5 cycles.
- Single FU: req=4'b0100, data lane 2=32'hDEAD_BEEF, RB index 3, valid 1 -> one cycle later grant=4'b0100, cdb_valid=1, cdb_data=32'hDEADBEEF, cdb_rb_index=3, cdb_fu=2, cdb_addr=0. With req held one extra cycle, the next cycle has cdb_valid=0 (mask).
- Round robin: req=4'b1111 held, each FU deasserting after its grant -> grants in order FU0, FU1, FU2, FU3 on consecutive cycles. Then with all re-requesting from ptr=0, FU0 is granted again.
- Storer broadcast: FU3 requests with addr lane 0=32'h0000_1000 and data 32'h55 -> cdb_fu=3, cdb_addr=32'h1000, cdb_data=32'h55.
- NULL and flush: FU1 requests with RB index 4'hF while FU2 requests with index 5 -> FU2 is granted and FU1 never is. Then flush=1 with FU0 requesting -> grant=0, cdb_valid=0, ptr unchanged (still 3).
- Async reset mid-stream: reset dropped between edges while cdb_valid=1 -> cdb_valid=0 and grant=0 within the same cycle; after release, the first grant starts from FU0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter and registered broadcast stage for the common data bus.
// One FU is granted per cycle; the winner's lanes are captured into the CDB registers.
module cdb_arbiter #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned FU_NUM     = 4,
  parameter int unsigned STORER_NUM = 1,
  parameter int unsigned RB_INDEX   = 4,
  parameter int unsigned FU_ID_W    = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_flush,
  input  logic [FU_NUM-1:0]               i_req,
  input  logic [WORD_SIZE*FU_NUM-1:0]     i_data_bus,
  input  logic [FU_NUM-1:0]               i_valid_bus,
  input  logic [STORER_NUM*WORD_SIZE-1:0] i_addr_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]      i_rb_index_bus,
  output logic [FU_NUM-1:0]               o_grant,
  output logic                            o_cdb_valid,
  output logic [WORD_SIZE-1:0]            o_cdb_data,
  output logic                            o_cdb_ok,
  output logic [WORD_SIZE-1:0]            o_cdb_addr,
  output logic [RB_INDEX-1:0]             o_cdb_rb_index,
  output logic [FU_ID_W-1:0]              o_cdb_fu
);

  localparam logic [RB_INDEX-1:0] RbNull = {RB_INDEX{1'b1}};

  logic [FU_ID_W-1:0]   r_ptr;
  logic [FU_NUM-1:0]    r_grant;
  logic                 r_valid;
  logic [WORD_SIZE-1:0] r_data;
  logic                 r_ok;
  logic [WORD_SIZE-1:0] r_addr;
  logic [RB_INDEX-1:0]  r_rb;
  logic [FU_ID_W-1:0]   r_fu;

  logic [FU_NUM-1:0]    w_elig;
  logic                 w_found;
  logic [FU_ID_W-1:0]   w_win;
  logic [FU_NUM-1:0]    w_onehot;
  logic [WORD_SIZE-1:0] w_data;
  logic                 w_ok;
  logic [WORD_SIZE-1:0] w_addr;
  logic [RB_INDEX-1:0]  w_rb;
  logic [FU_ID_W-1:0]   w_ptr_next;

  // The FU currently holding its grant is masked so it cannot be granted twice in a row.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      w_elig[i] = i_req[i] && (i_rb_index_bus[i*RB_INDEX +: RB_INDEX] != RbNull) && !r_grant[i];
    end
  end

  // First pass covers ptr..FU_NUM-1; second pass wraps to the lowest index below ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      if (!w_found && w_elig[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_win   = FU_ID_W'(i);
      end
    end
    for (int i = 0; i < FU_NUM; i++) begin
      if (!w_found && w_elig[i]) begin
        w_found = 1'b1;
        w_win   = FU_ID_W'(i);
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    w_data   = '0;
    w_ok     = 1'b0;
    w_rb     = '0;
    w_addr   = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      if (w_win == FU_ID_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_data      = i_data_bus[i*WORD_SIZE +: WORD_SIZE];
        w_ok        = i_valid_bus[i];
        w_rb        = i_rb_index_bus[i*RB_INDEX +: RB_INDEX];
      end
    end
    // Storers occupy the top FU numbers; their address lanes start at 0.
    for (int j = 0; j < STORER_NUM; j++) begin
      if (w_win == FU_ID_W'(j + FU_NUM - STORER_NUM)) begin
        w_addr = i_addr_bus[j*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_comb begin
    if (w_win == FU_ID_W'(FU_NUM - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_win + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ok    <= 1'b0;
      r_addr  <= '0;
      r_rb    <= RbNull;
      r_fu    <= '0;
    end else if (i_flush || !w_found) begin
      r_grant <= '0;
      r_valid <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_next;
      r_grant <= w_onehot;
      r_valid <= 1'b1;
      r_data  <= w_data;
      r_ok    <= w_ok;
      r_addr  <= w_addr;
      r_rb    <= w_rb;
      r_fu    <= w_win;
    end
  end

  assign o_grant        = r_grant;
  assign o_cdb_valid    = r_valid;
  assign o_cdb_data     = r_data;
  assign o_cdb_ok       = r_ok;
  assign o_cdb_addr     = r_addr;
  assign o_cdb_rb_index = r_rb;
  assign o_cdb_fu       = r_fu;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: constant vector table, directed corner sequences, and
// randomized traffic against a round-robin reference model.
module tb_cdb_arbiter;

  localparam int W = 32;
  localparam int N = 4;
  localparam int S = 1;
  localparam int R = 4;
  localparam int FW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic [N-1:0]   req = '0;
  logic [W*N-1:0] data_bus = '0;
  logic [N-1:0]   valid_bus = '0;
  logic [S*W-1:0] addr_bus = '0;
  logic [N*R-1:0] rb_bus = '1;

  logic [N-1:0]   grant;
  logic           cdb_valid;
  logic [W-1:0]   cdb_data;
  logic           cdb_ok;
  logic [W-1:0]   cdb_addr;
  logic [R-1:0]   cdb_rb;
  logic [FW-1:0]  cdb_fu;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model state
  int           m_ptr;
  int           m_gnt;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ok;
  logic [W-1:0] m_addr;
  logic [R-1:0] m_rb;
  int           m_fu;

  cdb_arbiter #(
    .WORD_SIZE(W), .FU_NUM(N), .STORER_NUM(S), .RB_INDEX(R), .FU_ID_W(FW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_flush(flush),
    .i_req(req),
    .i_data_bus(data_bus),
    .i_valid_bus(valid_bus),
    .i_addr_bus(addr_bus),
    .i_rb_index_bus(rb_bus),
    .o_grant(grant),
    .o_cdb_valid(cdb_valid),
    .o_cdb_data(cdb_data),
    .o_cdb_ok(cdb_ok),
    .o_cdb_addr(cdb_addr),
    .o_cdb_rb_index(cdb_rb),
    .o_cdb_fu(cdb_fu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_gnt = -1; m_valid = 1'b0; m_data = '0; m_ok = 1'b0;
    m_addr = '0; m_rb = '1; m_fu = 0;
  endtask

  task automatic model_edge();
    int w;
    int i;
    w = -1;
    if (flush) begin
      m_gnt = -1;
      m_valid = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (w < 0 && req[i] && rb_bus[i*R +: R] != '1 && m_gnt != i) w = i;
      end
      if (w >= 0) begin
        m_gnt = w; m_valid = 1'b1; m_fu = w;
        m_data = data_bus[w*W +: W];
        m_ok = valid_bus[w];
        m_rb = rb_bus[w*R +: R];
        m_addr = (w >= N - S) ? addr_bus[(w - (N - S))*W +: W] : '0;
        m_ptr = (w + 1) % N;
      end else begin
        m_gnt = -1;
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = (m_gnt >= 0) ? (N'(1) << m_gnt) : '0;
    chk({tag, ".grant"}, 64'(grant), 64'(eg));
    chk({tag, ".valid"}, 64'(cdb_valid), 64'(m_valid));
    chk({tag, ".data"}, 64'(cdb_data), 64'(m_data));
    chk({tag, ".ok"}, 64'(cdb_ok), 64'(m_ok));
    chk({tag, ".addr"}, 64'(cdb_addr), 64'(m_addr));
    chk({tag, ".rb"}, 64'(cdb_rb), 64'(m_rb));
    chk({tag, ".fu"}, 64'(cdb_fu), 64'(m_fu));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".grant"}, 64'(grant), 64'h0);
    chk({tag, ".valid"}, 64'(cdb_valid), 64'h0);
    chk({tag, ".data"}, 64'(cdb_data), 64'h0);
    chk({tag, ".ok"}, 64'(cdb_ok), 64'h0);
    chk({tag, ".addr"}, 64'(cdb_addr), 64'h0);
    chk({tag, ".rb"}, 64'(cdb_rb), 64'hF);
    chk({tag, ".fu"}, 64'(cdb_fu), 64'h0);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] rb;
    logic        flush;
    logic [3:0]  exp_grant;
    logic        exp_valid;
    logic [1:0]  exp_fu;
  } vec_t;

  vec_t tbl[12];

  initial begin
    model_reset();
    tbl[0]  = '{4'b1111, 16'h3210, 1'b0, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b1110, 16'h3210, 1'b0, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'b1100, 16'h3210, 1'b0, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b1000, 16'h3210, 1'b0, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'b1111, 16'h3210, 1'b0, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b0001, 16'h3210, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[6]  = '{4'b0001, 16'h3210, 1'b0, 4'b0001, 1'b1, 2'd0};
    tbl[7]  = '{4'b0110, 16'h35F0, 1'b0, 4'b0100, 1'b1, 2'd2};
    tbl[8]  = '{4'b0010, 16'h35F0, 1'b0, 4'b0000, 1'b0, 2'd2};
    tbl[9]  = '{4'b0001, 16'h3210, 1'b1, 4'b0000, 1'b0, 2'd2};
    tbl[10] = '{4'b0011, 16'h3210, 1'b0, 4'b0001, 1'b1, 2'd0};
    tbl[11] = '{4'b0010, 16'h3210, 1'b0, 4'b0010, 1'b1, 2'd1};

    // Reset held for 3 cycles, then idle
    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle.grant", 64'(grant), 64'h0);
      chk("idle.valid", 64'(cdb_valid), 64'h0);
    end
    chk("idle.rb", 64'(cdb_rb), 64'hF);

    // Vector table
    for (int i = 0; i < N; i++) data_bus[i*W +: W] = 32'hA000_0000 + i;
    valid_bus = '1;
    for (int v = 0; v < 12; v++) begin
      req = tbl[v].req; rb_bus = tbl[v].rb; flush = tbl[v].flush;
      tick();
      chk($sformatf("tbl%0d.grant", v), 64'(grant), 64'(tbl[v].exp_grant));
      chk($sformatf("tbl%0d.valid", v), 64'(cdb_valid), 64'(tbl[v].exp_valid));
      chk($sformatf("tbl%0d.fu", v), 64'(cdb_fu), 64'(tbl[v].exp_fu));
    end
    flush = 1'b0;

    // Single FU broadcast (ptr is 2 here), then held request is masked
    req = 4'b0100; rb_bus = 16'h0300; data_bus[2*W +: W] = 32'hDEAD_BEEF;
    valid_bus = 4'b0100;
    tick();
    chk("single.grant", 64'(grant), 64'h4);
    chk("single.valid", 64'(cdb_valid), 64'h1);
    chk("single.data", 64'(cdb_data), 64'hDEAD_BEEF);
    chk("single.ok", 64'(cdb_ok), 64'h1);
    chk("single.rb", 64'(cdb_rb), 64'h3);
    chk("single.fu", 64'(cdb_fu), 64'h2);
    chk("single.addr", 64'(cdb_addr), 64'h0);
    tick();
    chk("mask.valid", 64'(cdb_valid), 64'h0);
    chk("mask.grant", 64'(grant), 64'h0);
    chk("mask.data_hold", 64'(cdb_data), 64'hDEAD_BEEF);
    req = '0;

    // Storer broadcast (ptr is 3)
    req = 4'b1000; rb_bus = 16'h7000; data_bus[3*W +: W] = 32'h55;
    addr_bus = 32'h0000_1000; valid_bus = 4'b1000;
    tick();
    chk("store.fu", 64'(cdb_fu), 64'h3);
    chk("store.addr", 64'(cdb_addr), 64'h1000);
    chk("store.data", 64'(cdb_data), 64'h55);
    chk("store.rb", 64'(cdb_rb), 64'h7);
    req = '0;

    // Async reset in the middle of a broadcast
    req = 4'b0001; rb_bus = 16'h0001;
    tick();
    chk("pre_rst.valid", 64'(cdb_valid), 64'h1);
    req = 4'b1111; rb_bus = 16'h4321;
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    tick();
    tick();
    chk("rst_hold.grant", 64'(grant), 64'h0);
    chk("rst_hold.valid", 64'(cdb_valid), 64'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst.grant", 64'(grant), 64'h1);
    chk("post_rst.fu", 64'(cdb_fu), 64'h0);

    // Randomized traffic against the reference model
    req = '0; rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        data_bus[i*W +: W] = $urandom;
        rb_bus[i*R +: R] = R'($urandom_range(0, (1 << R) - 1));
      end
      valid_bus = N'($urandom_range(0, (1 << N) - 1));
      addr_bus = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      tick();
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
